// File: rtl/vga_timing_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_timing_ctrl : VGA raster timing, pixel coordinate publish, latency-matched
//                   sync/colour pin stage.                         Rev 1.0
// ============================================================================
module vga_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIX_LAT  = 1,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        vga_clk,
   input  logic        vga_rst,
   output logic [9:0]  x_pos,
   output logic [9:0]  y_pos,
   output logic        active,
   output logic        frame_start,
   input  logic [11:0] pixel_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);
   localparam int         C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] C_H_LAST  = 10'(C_H_TOTAL - 1);
   localparam logic [9:0] C_V_LAST  = 10'(C_V_TOTAL - 1);
   localparam logic [9:0] C_H_ACT   = 10'(H_ACTIVE);
   localparam logic [9:0] C_V_ACT   = 10'(V_ACTIVE);
   localparam logic [9:0] C_HS_BEG  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] C_HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] C_VS_BEG  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] C_VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] r_h_cnt;
   logic [9:0] r_v_cnt;
   logic       w_hs_raw;
   logic       w_vs_raw;
   logic       w_hs_d;
   logic       w_vs_d;
   logic       w_de_d;

   always_ff @(posedge vga_clk or posedge vga_rst) begin
      if (vga_rst) begin
         r_h_cnt <= 10'd0;
         r_v_cnt <= 10'd0;
      end else if (r_h_cnt == C_H_LAST) begin
         r_h_cnt <= 10'd0;
         r_v_cnt <= (r_v_cnt == C_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 10'd1;
      end
   end

   assign active      = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
   assign frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
   assign x_pos       = active ? r_h_cnt : 10'd0;
   assign y_pos       = active ? r_v_cnt : 10'd0;
   assign w_hs_raw    = (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
   assign w_vs_raw    = (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);

   // Stages carry "sync asserted" flags, so the idle reset value is 0 for any polarity.
   generate
      if (PIX_LAT == 0) begin : g_no_lat
         assign w_hs_d = w_hs_raw;
         assign w_vs_d = w_vs_raw;
         assign w_de_d = active;
      end else begin : g_lat
         logic [PIX_LAT-1:0] r_hs_sr;
         logic [PIX_LAT-1:0] r_vs_sr;
         logic [PIX_LAT-1:0] r_de_sr;

         always_ff @(posedge vga_clk or posedge vga_rst) begin
            if (vga_rst) begin
               r_hs_sr <= '0;
               r_vs_sr <= '0;
               r_de_sr <= '0;
            end else begin
               for (int i = PIX_LAT - 1; i > 0; i--) begin
                  r_hs_sr[i] <= r_hs_sr[i-1];
                  r_vs_sr[i] <= r_vs_sr[i-1];
                  r_de_sr[i] <= r_de_sr[i-1];
               end
               r_hs_sr[0] <= w_hs_raw;
               r_vs_sr[0] <= w_vs_raw;
               r_de_sr[0] <= active;
            end
         end

         assign w_hs_d = r_hs_sr[PIX_LAT-1];
         assign w_vs_d = r_vs_sr[PIX_LAT-1];
         assign w_de_d = r_de_sr[PIX_LAT-1];
      end
   endgenerate

   always_ff @(posedge vga_clk or posedge vga_rst) begin
      if (vga_rst) begin
         vga_r  <= 4'h0;
         vga_g  <= 4'h0;
         vga_b  <= 4'h0;
         vga_hs <= ~SYNC_POL;
         vga_vs <= ~SYNC_POL;
      end else begin
         vga_hs <= w_hs_d ? SYNC_POL : ~SYNC_POL;
         vga_vs <= w_vs_d ? SYNC_POL : ~SYNC_POL;
         {vga_b, vga_g, vga_r} <= w_de_d ? pixel_data : 12'h000;
      end
   end
endmodule
`default_nettype wire
